// File: rtl/arm_mc_ctrl_pkg.sv
// Shared definitions for the multicycle ARM controller: FSM states, ALU codes,
// condition codes, opcode/cmd fields and condition evaluation.
package arm_mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_MULEX
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b110;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] MUL_PAT = 4'b1001;
  localparam logic [3:0] RD_PC   = 4'd15;

  // The never condition (1111) falls into the default and reads as false.
  function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_mc_condlogic.sv
// NZCV flag register and condition-execute evaluation for the multicycle controller.
module arm_mc_condlogic
  import arm_mc_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic [1:0] i_flag_w,
  output logic       o_cond_ex
);

  logic [3:0] r_flags;

  assign o_cond_ex = cond_met(i_cond, r_flags);

  // i_flag_w[1] loads N,Z; i_flag_w[0] loads C,V; both only when the condition holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= FLAGS_RST;
    end else begin
      if (i_flag_w[1] && o_cond_ex) r_flags[3:2] <= i_alu_flags[3:2];
      if (i_flag_w[0] && o_cond_ex) r_flags[1:0] <= i_alu_flags[1:0];
    end
  end

endmodule

// File: rtl/arm_mc_ctrl.sv
// Multicycle ARM controller: main FSM, instruction decoder and datapath control.
// Optional MUL support (MULEX state) is enabled by defining MC_MUL_EN.
module arm_mc_ctrl
  import arm_mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:4]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Undef,
  output logic                 Busy
);

  localparam logic W_FULL_ALU = (ALUCTRL_W == 32'd3);

  state_e     r_state;
  logic [3:0] w_cond, w_cmd, w_rd;
  logic [1:0] w_op;
  logic       w_imm, w_s, w_load;

  assign w_cond = Instr[31:28];
  assign w_op   = Instr[27:26];
  assign w_imm  = Instr[25];
  assign w_cmd  = Instr[24:21];
  assign w_s    = Instr[20];
  assign w_load = Instr[20];
  assign w_rd   = Instr[15:12];

  logic w_mul_pat, w_is_mul, w_unused;
  assign w_mul_pat = (w_op == OP_DP) && (w_cmd == CMD_AND) && (Instr[7:4] == MUL_PAT);
`ifdef MC_MUL_EN
  assign w_is_mul = w_mul_pat;
`else
  assign w_is_mul = 1'b0;
`endif
  // Register-number fields are datapath concerns, not control
  assign w_unused = &{1'b0, Instr[19:16], Instr[11:8], w_mul_pat};

  // Data-processing decode: support, ALU op, compare-only and logical-class flags
  logic       w_dp_ok, w_dp_nowrite, w_dp_logic;
  logic [2:0] w_dp_alu;
  always_comb begin
    w_dp_ok      = 1'b1;
    w_dp_nowrite = 1'b0;
    w_dp_logic   = 1'b0;
    w_dp_alu     = ALU_ADD;
    if (w_is_mul) begin
      w_dp_alu   = ALU_MUL;
      w_dp_logic = 1'b1;
    end else begin
      case (w_cmd)
        CMD_ADD: w_dp_alu = ALU_ADD;
        CMD_SUB: w_dp_alu = ALU_SUB;
        CMD_AND: begin w_dp_alu = ALU_AND; w_dp_logic = 1'b1; end
        CMD_ORR: begin w_dp_alu = ALU_ORR; w_dp_logic = 1'b1; end
        CMD_EOR: begin w_dp_alu = ALU_EOR; w_dp_logic = 1'b1; w_dp_ok = W_FULL_ALU; end
        CMD_MOV: begin w_dp_alu = ALU_MOV; w_dp_logic = 1'b1; w_dp_ok = W_FULL_ALU; end
        CMD_CMP: begin w_dp_alu = ALU_SUB; w_dp_nowrite = 1'b1; end
        CMD_CMN: begin w_dp_alu = ALU_ADD; w_dp_nowrite = 1'b1; end
        CMD_TST: begin w_dp_alu = ALU_AND; w_dp_nowrite = 1'b1; w_dp_logic = 1'b1; end
        default: w_dp_ok = 1'b0;
      endcase
    end
  end

  logic w_undef_instr;
  assign w_undef_instr = (w_op == OP_UND) || ((w_op == OP_DP) && !w_dp_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          if (w_undef_instr)      r_state <= S_FETCH;
          else if (w_op == OP_MEM) r_state <= S_MEMADR;
          else if (w_op == OP_BR)  r_state <= S_BRANCH;
          else if (w_is_mul)       r_state <= S_MULEX;
          else if (w_imm)          r_state <= S_EXECI;
          else                     r_state <= S_EXECR;
        end
        S_MEMADR: r_state <= w_load ? S_MEMRD : S_MEMWR;
        S_MEMRD:  r_state <= S_MEMWB;
        S_EXECR,
        S_EXECI:  r_state <= w_dp_nowrite ? S_FETCH : S_ALUWB;
        S_MULEX:  r_state <= S_ALUWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Per-state datapath selects and unqualified write intents
  logic       w_irw, w_regw, w_memw, w_branch, w_fetch, w_wb, w_exec;
  logic [2:0] w_alu;
  always_comb begin
    w_irw     = 1'b0;
    w_regw    = 1'b0;
    w_memw    = 1'b0;
    w_branch  = 1'b0;
    w_fetch   = 1'b0;
    w_wb      = 1'b0;
    w_exec    = 1'b0;
    w_alu     = ALU_ADD;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (r_state)
      S_FETCH:  begin
        w_irw = 1'b1; w_fetch = 1'b1;
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_DECODE: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB:  begin ResultSrc = 2'b01; w_regw = 1'b1; w_wb = 1'b1; end
      S_MEMWR:  begin AdrSrc = 1'b1; w_memw = 1'b1; end
      S_EXECR:  begin w_alu = w_dp_alu; w_exec = 1'b1; end
      S_EXECI:  begin ALUSrcB = 2'b01; w_alu = w_dp_alu; w_exec = 1'b1; end
      S_MULEX:  begin w_alu = ALU_MUL; w_exec = 1'b1; end
      S_ALUWB:  begin w_regw = 1'b1; w_wb = 1'b1; end
      S_BRANCH: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (w_op)
      OP_MEM:  ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Logical ops (incl. TST, MUL) only touch N,Z; arithmetic ops touch all four
  logic [1:0] w_flag_w;
  logic       w_cond_ex;
  assign w_flag_w = (w_exec && (w_s || w_dp_nowrite)) ? {1'b1, !w_dp_logic} : 2'b00;

  arm_mc_condlogic #(
    .FLAGS_RST (FLAGS_RST)
  ) u_condlogic (
    .clk         (clk),
    .reset       (reset),
    .i_cond      (w_cond),
    .i_alu_flags (ALUFlags),
    .i_flag_w    (w_flag_w),
    .o_cond_ex   (w_cond_ex)
  );

  assign ALUControl = ALUCTRL_W'(w_alu);
  assign RegSrc     = {(w_op == OP_MEM) && !w_load, w_op == OP_BR};
  assign IRWrite    = !reset && w_irw;
  assign RegWrite   = !reset && w_regw && w_cond_ex;
  assign MemWrite   = !reset && w_memw && w_cond_ex;
  assign PCWrite    = !reset && (w_fetch ||
                      (w_cond_ex && (w_branch || (w_wb && (w_rd == RD_PC)))));
  assign Undef      = (r_state == S_DECODE) && w_undef_instr;
  assign Busy       = (r_state != S_FETCH);

endmodule

// File: tb/tb_arm_mc_ctrl.sv
// Self-checking bench for arm_mc_ctrl: directed ISA scenarios plus random
// instruction streams checked cycle by cycle against an instruction-level model.
`timescale 1ns/1ps
module tb_arm_mc_ctrl;

  localparam int unsigned AW = 3;
  localparam logic [15:0] FETCH_VEC = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                       2'b01, 2'b10, 2'b10, 3'b000};

  logic          clk = 1'b0;
  logic          reset;
  logic [31:4]   Instr;
  logic [3:0]    ALUFlags;
  logic          PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, Undef, Busy;
  logic [1:0]    RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [AW-1:0] ALUControl;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] m_flags;

  typedef enum {P_FETCH, P_DEC, P_MADR, P_MRD, P_MWB, P_MWR, P_EX, P_MUL, P_AWB, P_BR} phase_e;

  arm_mc_ctrl #(.ALUCTRL_W(AW), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Undef(Undef), .Busy(Busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs_vec();
    return {Busy, PCWrite, RegWrite, MemWrite, IRWrite, Undef, AdrSrc,
            ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp,
                     input logic [15:0] mask);
    n_vec++;
    assert ((obs & mask) === (exp & mask)) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (mask %h)", tag, obs & mask, exp & mask, mask);
    end
  endtask

  // ARM condition: base test on cond[3:1], inverted by cond[0]; 1110 true, 1111 false
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, r;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    return r ^ c[0];
  endfunction

  task automatic dp_info(input logic [3:0] cmd, output logic ok, output logic [2:0] alu,
                         output logic nowr, output logic lgc);
    ok = 1'b1; nowr = 1'b0; lgc = 1'b0; alu = 3'd0;
    case (cmd)
      4'b0100: alu = 3'd0;
      4'b0010: alu = 3'd1;
      4'b0000: begin alu = 3'd2; lgc = 1'b1; end
      4'b1100: begin alu = 3'd3; lgc = 1'b1; end
      4'b0001: begin alu = 3'd4; lgc = 1'b1; ok = (AW == 3); end
      4'b1101: begin alu = 3'd5; lgc = 1'b1; ok = (AW == 3); end
      4'b1010: begin alu = 3'd1; nowr = 1'b1; end
      4'b1011: begin alu = 3'd0; nowr = 1'b1; end
      4'b1000: begin alu = 3'd2; nowr = 1'b1; lgc = 1'b1; end
      default: ok = 1'b0;
    endcase
  endtask

  // Runs one instruction from its FETCH cycle; stop_at >= 0 returns after that phase index
  task automatic do_instr(input string tag, input logic [31:4] ins, input logic [3:0] af,
                          input int stop_at, output int dut_cyc);
    phase_e     ph[$];
    logic [1:0] op;
    logic       ok, nowr, lgc, mul, unsup, pass, ld;
    logic [2:0] alu;
    logic [15:0] exp, mask;
    op = ins[27:26];
    ld = ins[20];
    dp_info(ins[24:21], ok, alu, nowr, lgc);
`ifdef MC_MUL_EN
    mul = (op == 2'b00) && (ins[24:21] == 4'b0000) && (ins[7:4] == 4'b1001);
`else
    mul = 1'b0;
`endif
    if (mul) begin alu = 3'd6; lgc = 1'b1; nowr = 1'b0; end
    unsup = (op == 2'b11) || ((op == 2'b00) && !ok && !mul);
    ph.push_back(P_FETCH);
    ph.push_back(P_DEC);
    if (!unsup) begin
      case (op)
        2'b01: begin
          ph.push_back(P_MADR);
          if (ld) begin ph.push_back(P_MRD); ph.push_back(P_MWB); end
          else ph.push_back(P_MWR);
        end
        2'b10: ph.push_back(P_BR);
        default: begin
          ph.push_back(mul ? P_MUL : P_EX);
          if (!nowr) ph.push_back(P_AWB);
        end
      endcase
    end
    dut_cyc = 1;
    for (int k = 0; k < ph.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin Instr = ins; ALUFlags = af; end
      #1;
      if (k > 0 && Busy) dut_cyc++;
      pass = cond_pass(ins[31:28], m_flags);
      exp  = 16'h8000;
      mask = 16'hFC00;
      case (ph[k])
        P_FETCH: begin exp = FETCH_VEC; mask = 16'hFFFF; end
        P_DEC:   exp[10] = unsup;
        P_EX, P_MUL: begin exp[2:0] = alu; mask = 16'hFC07; end
        P_AWB:   begin exp[13] = pass; exp[14] = pass && (ins[15:12] == 4'd15); end
        P_MWB:   begin
          exp[13] = pass; exp[14] = pass && (ins[15:12] == 4'd15);
          exp[4:3] = 2'b01; mask = 16'hFC18;
        end
        P_MWR:   exp[12] = pass;
        P_BR:    exp[14] = pass;
        default: ;
      endcase
      chk($sformatf("%s/%s", tag, ph[k].name()), obs_vec(), exp, mask);
      if (ph[k] == P_DEC && op != 2'b11)
        chk($sformatf("%s/srcsel", tag), {12'h000, RegSrc, ImmSrc},
            {12'h000, (op == 2'b01) && !ld, op == 2'b10, op}, 16'h000F);
      if ((ph[k] == P_EX || ph[k] == P_MUL) && pass && (ins[20] || nowr)) begin
        m_flags[3:2] = af[3:2];
        if (!lgc) m_flags[1:0] = af[1:0];
      end
      if (stop_at >= 0 && k == stop_at) break;
    end
  endtask

  initial begin
    int          cyc;
    logic [31:4] r;
    int          cat;
    reset    = 1'b1;
    Instr    = '0;
    ALUFlags = '0;
    m_flags  = 4'b0000;
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", obs_vec(), 16'h0000, 16'hFC00);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("first_fetch", obs_vec(), FETCH_VEC, 16'hFFFF);

    do_instr("add_imm", 28'hE280200, 4'b0000, -1, cyc);
    chk("add_lat", 16'(cyc), 16'd4, 16'hFFFF);
    do_instr("subs_z", 28'hE251100, 4'b0100, -1, cyc);
    do_instr("beq_taken", 28'h0A00000, 4'b0000, -1, cyc);
    chk("br_lat", 16'(cyc), 16'd3, 16'hFFFF);
    do_instr("subs_nz", 28'hE251100, 4'b0000, -1, cyc);
    do_instr("beq_not", 28'h0A00000, 4'b0000, -1, cyc);
    do_instr("cmp", 28'hE151000, 4'b1000, -1, cyc);
    chk("cmp_lat", 16'(cyc), 16'd3, 16'hFFFF);
    do_instr("blt", 28'hBA00000, 4'b0000, -1, cyc);
    do_instr("ldr", 28'hE590206, 4'b0000, -1, cyc);
    chk("ldr_lat", 16'(cyc), 16'd5, 16'hFFFF);
    do_instr("str", 28'hE580206, 4'b0000, -1, cyc);
    chk("str_lat", 16'(cyc), 16'd4, 16'hFFFF);
    do_instr("undef_op11", 28'hEC00000, 4'b0000, -1, cyc);
    chk("undef_lat", 16'(cyc), 16'd2, 16'hFFFF);
    do_instr("mul_pat", 28'hE000029, 4'b0000, -1, cyc);
    chk("mul_lat", 16'(cyc), 16'd4, 16'hFFFF);

    // Set Z, then reset in the middle of an LDR and confirm flags return to 0000
    do_instr("cmp_z", 28'hE151000, 4'b0100, -1, cyc);
    do_instr("ldr_abort", 28'hE590206, 4'b0000, 3, cyc);
    reset = 1'b1;
    #1 chk("mid_rst", obs_vec(), 16'h0000, 16'hFC00);
    m_flags = 4'b0000;
    @(posedge clk);
    #1 chk("mid_rst_hold", obs_vec(), 16'h0000, 16'hFC00);
    reset = 1'b0;
    #1 chk("rst_fetch", obs_vec(), FETCH_VEC, 16'hFFFF);
    do_instr("beq_after_rst", 28'h0A00000, 4'b0000, -1, cyc);
    do_instr("bne_after_rst", 28'h1A00000, 4'b0000, -1, cyc);

    for (int i = 0; i < 300; i++) begin
      r   = 28'($urandom());
      cat = $urandom_range(0, 9);
      if (cat < 5)      r[27:26] = 2'b00;
      else if (cat < 7) r[27:26] = 2'b01;
      else if (cat < 9) r[27:26] = 2'b10;
      else              r[27:26] = 2'b11;
      if ($urandom_range(0, 2) == 0) r[31:28] = 4'hE;
      do_instr($sformatf("rnd%0d", i), r, 4'($urandom()), -1, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/arm_mc_ctrl.md
ARM_MC_CTRL -- requirements
Module: arm_mc_ctrl

Interface
REQ-001 Parameter ALUCTRL_W, default 3: ALUControl width; legal values 2 and 3.
REQ-002 Parameter FLAGS_RST, default 4'b0000: reset value of the internal NZCV register.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 Instr  in  [31:4]  current instruction register contents (cond, op, funct, Rd; bits 7:4 used only under MC_MUL_EN).
REQ-006 ALUFlags  in  4  NZCV from datapath ALU, valid in execute states.
REQ-007 PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc  out  1 each  datapath enables/selects.
REQ-008 RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  out  2 each  datapath mux selects.
REQ-009 ALUControl  out  ALUCTRL_W  ALU operation.
REQ-010 Undef  out  1  one-cycle pulse in DECODE when the instruction is unsupported.
REQ-011 Busy  out  1  high in every state except FETCH.

Function
REQ-012 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH (plus MULEX under MC_MUL_EN).
REQ-013 FETCH -> DECODE always; FETCH drives IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD, PCWrite=1.
REQ-014 DECODE: op=01 -> MEMADR; op=10 -> BRANCH; op=00 with funct[5]=1 -> EXECI, else EXECR; op=11 or unsupported cmd -> Undef=1, next FETCH.
REQ-015 MEMADR -> MEMRD if L=1, else MEMWR; MEMRD -> MEMWB; MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
REQ-016 EXECR/EXECI -> ALUWB, except CMP/CMN/TST (NoWrite), which go directly to FETCH.
REQ-017 Latencies: data processing 4 cycles (3 for NoWrite), STR 4, LDR 5, branch 3.
REQ-018 ALUControl encoding: ADD 000, SUB 001, AND 010, ORR 011, EOR 100, MOV 101 (passes SrcB), MUL 110; with ALUCTRL_W=2 only codes 00-11 exist and EOR/MOV decode as Undef.
REQ-019 CondEx computed combinationally from Instr[31:28] and the registered NZCV for all 15 ARM conditions; cond=1111 treated as false.
REQ-020 RegWrite = RegW & CondEx, MemWrite = MemW & CondEx; PCWrite = FETCH | (BRANCH & CondEx) | (ALUWB/MEMWB with Rd=15 & CondEx).
REQ-021 NZCV register loads ALUFlags on the clock edge ending EXECR/EXECI when S=1 and CondEx; N,Z only for logical ops (C,V held); CMP/CMN/TST always update.
REQ-022 A failed condition still walks the full state sequence with all write enables low.
REQ-023 ImmSrc: 00 for data processing, 01 for memory, 10 for branch; RegSrc[0]=1 in BRANCH path, RegSrc[1]=1 for STR.

Reset
REQ-024 reset asserted, at any state, forces state FETCH and NZCV=FLAGS_RST immediately; all write enables low while reset is high.
REQ-025 First FETCH outputs appear the first cycle after reset deasserts.

Configuration
REQ-026 Macro MC_MUL_EN: defined -> op=00, cmd=0000, Instr[7:4]=1001 decodes to MULEX (ALUControl=110) then ALUWB, requires ALUCTRL_W=3; undefined -> that pattern decodes as AND.

Structure
REQ-027 Shared package holds state enum, ALUControl codes, cond codes, op/cmd constants.
REQ-028 Sub-module arm_mc_condlogic holds NZCV register and CondEx logic; FSM and decoder stay in the top.

Verification
REQ-029 Reset mid-LDR (state MEMRD) -> next state FETCH, MemWrite=RegWrite=0, NZCV=0000.
REQ-030 ADD R2,R0,#5 (Instr[31:12]=E2802) -> FETCH,DECODE,EXECI,ALUWB; RegWrite=1 only in ALUWB; ALUControl=000.
REQ-031 SUBS with ALUFlags=0100, then BEQ (cond 0000) -> BRANCH with PCWrite=1; same BEQ after flags 0000 -> PCWrite=0 in BRANCH.
REQ-032 CMP R1,R2 with ALUFlags=1000 -> EXECR then FETCH (no ALUWB), RegWrite never 1, following BLT taken.
REQ-033 LDR R2,[R0,#96] -> 5 cycles, RegWrite=1 only in MEMWB, ResultSrc=01 there; STR -> MemWrite=1 only in MEMWR.
REQ-034 op=11 instruction -> Undef=1 for one cycle in DECODE, next state FETCH; MUL with MC_MUL_EN -> MULEX, ALUControl=110.
